// File: rtl/lab3_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lab3_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/lab3_serial_subtractor_full_subtractor_bit.sv
// One-bit full subtractor cell built from gate primitives, like the adder cells.
// Latency: purely combinational.
// Backpressure: none.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic x_xor_y;
  logic x_n;
  logic xy_eq;
  logic brw_gen;
  logic brw_prop;

  // d = x ^ y ^ bin
  xor g_x1 (x_xor_y, x, y);
  xor g_x2 (d, x_xor_y, bin);

  // bout = (~x & y) | (~(x ^ y) & bin)
  not g_n1 (x_n, x);
  not g_n2 (xy_eq, x_xor_y);
  and g_a1 (brw_gen, x_n, y);
  and g_a2 (brw_prop, xy_eq, bin);
  or  g_o1 (bout, brw_gen, brw_prop);

endmodule

// File: rtl/lab3_serial_subtractor.sv
// Bit-serial a - b, LSB first, through one full-subtractor cell and a borrow flop.
// Latency: result (done pulse) in the cycle after the WIDTH-th edge following acceptance.
// Backpressure: start is only sampled in IDLE; requests during RUN/DONE are dropped.
module lab3_serial_subtractor
  import lab3_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bor_q, bor_d;
  logic             bo_q, bo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic cell_d;
  logic cell_bout;
  logic last_bit;

  assign last_bit = (cnt_q == LAST_BIT);

  // The single cell always looks at the current LSBs and the working borrow.
  full_subtractor_bit u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (bor_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last bit, DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so no path from start to busy.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Datapath next-state: load on accept, shift one bit per RUN cycle, publish on the last bit.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    bor_d  = bor_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bo_d   = bo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          bor_d = 1'b0;
          cnt_d = '0;
        end
      end
      RUN: begin
        res_d = {cell_d, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bor_d = cell_bout;
        if (last_bit) begin
          // Clear rather than increment so the counter never wraps past WIDTH-1.
          cnt_d  = '0;
          diff_d = {cell_d, res_q[WIDTH-1:1]};
          bo_d   = cell_bout;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; reset discards any partial result and the previous answer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      bor_q  <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bo_q   <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      bor_q  <= bor_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      bo_q   <= bo_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = bo_q;

endmodule

// File: tb/tb_lab3_serial_subtractor.sv
// Bench for the bit-serial subtractor: WIDTH=8 and WIDTH=2 instances.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_lab3_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst_n8, start8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;
  // WIDTH=2 instance
  logic       rst_n2, start2, busy2, done2, bo2;
  logic [1:0] a2, b2, diff2;

  lab3_serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  lab3_serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n2), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] prev8 = '0;
  logic [1:0] prev2 = '0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic modulo 2^w.
  function automatic logic [31:0] ref_diff(input int unsigned x, input int unsigned y, input int w);
    return (x - y) & ((32'd1 << w) - 1);
  endfunction

  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ed, input logic eb, input string nm);
    int k;
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    chk({nm, " busy_after_accept"}, 32'(busy8), 32'd1);
    chk({nm, " diff_hold_during_run"}, 32'(diff8), 32'(prev8));
    k = 0;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, k, 8);
    chk({nm, " diff"}, 32'(diff8), 32'(ed));
    chk({nm, " borrow"}, 32'(bo8), 32'(eb));
    chk({nm, " busy_in_done"}, 32'(busy8), 32'd1);
    @(negedge clk);
    chk({nm, " done_pulse_end"}, {busy8, done8}, 32'd0);
    chk({nm, " diff_held"}, 32'(diff8), 32'(ed));
    prev8 = ed;
  endtask

  task automatic run2(input logic [1:0] av, input logic [1:0] bv, input string nm);
    int k;
    logic [1:0] ed;
    logic eb;
    ed = 2'(ref_diff(av, bv, 2));
    eb = (av < bv);
    @(negedge clk);
    a2 = av; b2 = bv; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    a2 = 2'($urandom); b2 = 2'($urandom);
    chk({nm, " diff_hold"}, 32'(diff2), 32'(prev2));
    k = 0;
    while (!done2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, k, 2);
    chk({nm, " diff"}, 32'(diff2), 32'(ed));
    chk({nm, " borrow"}, 32'(bo2), 32'(eb));
    @(negedge clk);
    chk({nm, " done_pulse_end"}, 32'(done2), 32'd0);
    prev2 = ed;
  endtask

  initial begin
    int k;
    int dones;
    logic [7:0] ra, rb;

    vecs[0] = '{a: 8'd200, b: 8'd55,  d: 8'd145,  bo: 1'b0};
    vecs[1] = '{a: 8'd55,  b: 8'd200, d: 8'h6F,   bo: 1'b1};
    vecs[2] = '{a: 8'd0,   b: 8'd1,   d: 8'hFF,   bo: 1'b1};
    vecs[3] = '{a: 8'h80,  b: 8'h80,  d: 8'h00,   bo: 1'b0};

    rst_n8 = 1'b0; rst_n2 = 1'b0;
    start8 = 1'b0; start2 = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    chk("reset busy8", 32'(busy8), 32'd0);
    chk("reset done8", 32'(done8), 32'd0);
    chk("reset diff8", 32'(diff8), 32'd0);
    chk("reset borrow8", 32'(bo8), 32'd0);
    chk("reset busy2/done2", {busy2, done2}, 32'd0);
    rst_n8 = 1'b1; rst_n2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle no start busy8", 32'(busy8), 32'd0);

    // Directed table
    for (int i = 0; i < 4; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, $sformatf("vec%0d", i));
    end

    // Random operands against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i == 5) rb = ra;
      run8(ra, rb, 8'(ref_diff(ra, rb, 8)), (ra < rb), $sformatf("rnd%0d", i));
    end

    // start held high; a changes during RUN; next accept only at E(WIDTH+2)
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd3; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'd99;
    k = 0; dones = 0;
    while (dones == 0 && k < 40) begin
      @(negedge clk);
      k++;
      if (done8) dones++;
    end
    chk("held_start first latency", k, 8);
    chk("held_start first diff", 32'(diff8), 32'd7);
    @(negedge clk); k++;
    chk("held_start idle gap busy", 32'(busy8), 32'd0);
    @(negedge clk); k++;
    chk("held_start re-accept busy", 32'(busy8), 32'd1);
    while (dones == 1 && k < 60) begin
      @(negedge clk);
      k++;
      if (done8) dones++;
    end
    chk("held_start second done cycle", k, 18);
    chk("held_start second diff", 32'(diff8), 32'd96);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("held_start no third accept", 32'(busy8), 32'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd4; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset busy", 32'(busy8), 32'd1);
    rst_n8 = 1'b0;
    #1;
    chk("midrun_reset busy", 32'(busy8), 32'd0);
    chk("midrun_reset done", 32'(done8), 32'd0);
    chk("midrun_reset diff", 32'(diff8), 32'd0);
    chk("midrun_reset borrow", 32'(bo8), 32'd0);
    @(negedge clk);
    rst_n8 = 1'b1;
    prev8 = 8'd0;
    run8(8'd9, 8'd4, 8'd5, 1'b0, "post_reset");

    // WIDTH=2: every operand pair
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        run2(2'(x), 2'(y), $sformatf("w2_%0d_%0d", x, y));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
